// File: rtl/rom_cache_pkg.sv
// Shared types for rom_cache: FSM state encoding, statistics width and line-word field offsets.
// Line word layout, MSB first: {valid, tag, data}.
package rom_cache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_FILL   = 3'd2,
        ST_DONE   = 3'd3,
        ST_FLUSH  = 3'd4
    } state_t;

    localparam int              STAT_W   = 16;
    localparam logic [STAT_W-1:0] STAT_MAX = 16'hFFFF;
    localparam logic [STAT_W-1:0] STAT_ONE = 16'd1;

    localparam int LINE_DATA_LSB = 0;

    function automatic int line_tag_lsb(input int data_w);
        return LINE_DATA_LSB + data_w;
    endfunction

    function automatic int line_valid_bit(input int data_w, input int tag_w);
        return line_tag_lsb(data_w) + tag_w;
    endfunction

    function automatic int line_width(input int data_w, input int tag_w);
        return line_valid_bit(data_w, tag_w) + 1;
    endfunction

endpackage

// File: rtl/rom_cache_if.sv
// Read-side (cache_*) and SDRAM-side (rom_*) request/strobe bundle of rom_cache.
// Level requests, one-cycle valid strobes; no backpressure beyond holding the request.
interface rom_cache_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 32
);
    logic              cache_req;
    logic [ADDR_W-1:0] cache_addr;
    logic              cache_valid;
    logic [DATA_W-1:0] cache_data;
    logic              rom_req;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              rom_valid;

    modport master (
        output cache_req, cache_addr, rom_data, rom_valid,
        input  cache_valid, cache_data, rom_req, rom_addr
    );

    modport slave (
        input  cache_req, cache_addr, rom_data, rom_valid,
        output cache_valid, cache_data, rom_req, rom_addr
    );
endinterface

// File: rtl/dual_port_ram.sv
// Simple dual-port RAM: port A writes, port B reads with one-cycle registered latency.
// No backpressure; contents are not reset.
module dual_port_ram #(
    parameter int WIDTH   = 8,
    parameter int DEPTH_W = 4
) (
    input  logic               clk,
    input  logic               a_we,
    input  logic [DEPTH_W-1:0] a_addr,
    input  logic [WIDTH-1:0]   a_wdata,
    input  logic [DEPTH_W-1:0] b_addr,
    output logic [WIDTH-1:0]   b_rdata
);
    logic [WIDTH-1:0] mem [2**DEPTH_W];

    always_ff @(posedge clk) begin
        if (a_we) begin
            mem[a_addr] <= a_wdata;
        end
    end

    always_ff @(posedge clk) begin
        b_rdata <= mem[b_addr];
    end
endmodule

// File: rtl/rom_cache_sat_cnt.sv
// Saturating statistics counter, cleared only by reset; sticks at all-ones.
// Counts on the edge where inc is high; no backpressure.
module rom_cache_sat_cnt
    import rom_cache_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    output logic [STAT_W-1:0] count
);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (count != STAT_MAX)) begin
            count <= count + STAT_ONE;
        end
    end
endmodule

// File: rtl/rom_cache.sv
// Direct-mapped one-word-per-line read cache in front of an SDRAM port. Hit: cache_valid 2 cycles after req.
// Backpressure: requester holds cache_req until served; misses wait on rom_valid; flushes wait for IDLE.
module rom_cache
    import rom_cache_pkg::*;
#(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 32,
    parameter int IDX_W  = 9
) (
    input  logic              clk,
    input  logic              reset,
    rom_cache_if.slave        bus,
    input  logic              flush,
    output logic              flush_busy,
    output logic [STAT_W-1:0] hit_count,
    output logic [STAT_W-1:0] miss_count
);
    localparam int TAG_W     = ADDR_W - IDX_W;
    localparam int TAG_LSB   = line_tag_lsb(DATA_W);
    localparam int VALID_BIT = line_valid_bit(DATA_W, TAG_W);
    localparam int LINE_W    = line_width(DATA_W, TAG_W);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  flush_idx_q, flush_idx_d;
    logic              flush_pend_q, flush_pend_d;
    logic              cache_valid_q, cache_valid_d;
    logic [DATA_W-1:0] cache_data_q, cache_data_d;
    logic              rom_req_q, rom_req_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              hit_inc, miss_inc;

    logic              ram_we;
    logic [IDX_W-1:0]  ram_waddr;
    logic [LINE_W-1:0] ram_wdata;
    logic [LINE_W-1:0] line_rd;

    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic              line_hit;

    assign req_idx  = bus.cache_addr[IDX_W-1:0];
    assign req_tag  = bus.cache_addr[ADDR_W-1:IDX_W];
    assign line_hit = line_rd[VALID_BIT] && (line_rd[TAG_LSB +: TAG_W] == req_tag);

    // Port B always tracks the request index, so LOOKUP sees the line read on the IDLE->LOOKUP edge.
    dual_port_ram #(
        .WIDTH   (LINE_W),
        .DEPTH_W (IDX_W)
    ) u_lines (
        .clk     (clk),
        .a_we    (ram_we),
        .a_addr  (ram_waddr),
        .a_wdata (ram_wdata),
        .b_addr  (req_idx),
        .b_rdata (line_rd)
    );

    always_comb begin
        state_d       = state_q;
        flush_idx_d   = flush_idx_q;
        flush_pend_d  = flush_pend_q | flush;
        cache_valid_d = 1'b0;
        cache_data_d  = cache_data_q;
        rom_req_d     = rom_req_q;
        rom_addr_d    = rom_addr_q;
        hit_inc       = 1'b0;
        miss_inc      = 1'b0;
        ram_we        = 1'b0;
        ram_waddr     = flush_idx_q;
        ram_wdata     = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (flush_pend_d) begin
                    state_d      = ST_FLUSH;
                    flush_idx_d  = '0;
                    flush_pend_d = 1'b0;
                end else if (bus.cache_req) begin
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (!bus.cache_req) begin
                    state_d = ST_IDLE;
                end else if (line_hit) begin
                    cache_data_d  = line_rd[LINE_DATA_LSB +: DATA_W];
                    cache_valid_d = 1'b1;
                    hit_inc       = 1'b1;
                    state_d       = ST_DONE;
                end else begin
                    rom_req_d  = 1'b1;
                    rom_addr_d = bus.cache_addr;
                    miss_inc   = 1'b1;
                    state_d    = ST_FILL;
                end
            end
            ST_FILL: begin
                // A dropped request wins over a same-edge rom_valid: nothing is written or returned.
                if (!bus.cache_req) begin
                    rom_req_d = 1'b0;
                    state_d   = ST_IDLE;
                end else if (bus.rom_valid) begin
                    cache_data_d  = bus.rom_data;
                    cache_valid_d = 1'b1;
                    rom_req_d     = 1'b0;
                    ram_we        = 1'b1;
                    ram_waddr     = req_idx;
                    ram_wdata[VALID_BIT]                 = 1'b1;
                    ram_wdata[TAG_LSB +: TAG_W]          = req_tag;
                    ram_wdata[LINE_DATA_LSB +: DATA_W]   = bus.rom_data;
                    state_d       = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!bus.cache_req) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                ram_we       = 1'b1;
                flush_pend_d = 1'b0;
                if (flush) begin
                    flush_idx_d = '0;
                end else if (flush_idx_q == '1) begin
                    state_d = ST_IDLE;
                end else begin
                    flush_idx_d = flush_idx_q + IDX_ONE;
                end
            end
            default: begin
                state_d = ST_FLUSH;
                flush_idx_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_FLUSH;
            flush_idx_q   <= '0;
            flush_pend_q  <= 1'b0;
            cache_valid_q <= 1'b0;
            cache_data_q  <= '0;
            rom_req_q     <= 1'b0;
            rom_addr_q    <= '0;
        end else begin
            state_q       <= state_d;
            flush_idx_q   <= flush_idx_d;
            flush_pend_q  <= flush_pend_d;
            cache_valid_q <= cache_valid_d;
            cache_data_q  <= cache_data_d;
            rom_req_q     <= rom_req_d;
            rom_addr_q    <= rom_addr_d;
        end
    end

    rom_cache_sat_cnt u_hit_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (hit_inc),
        .count (hit_count)
    );

    rom_cache_sat_cnt u_miss_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (miss_inc),
        .count (miss_count)
    );

    assign flush_busy      = (state_q == ST_FLUSH);
    assign bus.cache_valid = cache_valid_q;
    assign bus.cache_data  = cache_data_q;
    assign bus.rom_req     = rom_req_q;
    assign bus.rom_addr    = rom_addr_q;
endmodule

// File: tb/tb_rom_cache.sv
// Directed bench for rom_cache: stimulus pushes expected read data, a negedge monitor pops on cache_valid.
module tb_rom_cache;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        flush_busy;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    rom_cache_if #(.ADDR_W(20), .DATA_W(32)) bus();

    rom_cache #(.ADDR_W(20), .DATA_W(32), .IDX_W(9)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.slave),
        .flush      (flush),
        .flush_busy (flush_busy),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every cache_valid must match the oldest expected word.
    always @(negedge clk) begin
        if (reset && bus.cache_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got cache_valid with data 0x%0h, expected no cache_valid", bus.cache_data);
            end else begin
                chk("cache_data", bus.cache_data, exp_q.pop_front());
            end
        end
    end

    task automatic measure_flush(input string name);
        int w = 0;
        int n = 0;
        while (!flush_busy && w < 50) begin
            @(negedge clk);
            w++;
        end
        while (flush_busy && n < 2000) begin
            n++;
            @(negedge clk);
        end
        chk(name, 32'(n), 32'd512);
    endtask

    task automatic miss_read(input logic [19:0] a, input logic [31:0] d, input int dly,
                             input logic [15:0] exp_miss);
        bus.cache_req  = 1'b1;
        bus.cache_addr = a;
        @(negedge clk);
        @(negedge clk);
        chk("miss_rom_req", 32'(bus.rom_req), 32'd1);
        chk("miss_rom_addr", 32'(bus.rom_addr), 32'(a));
        chk("miss_count", 32'(miss_count), 32'(exp_miss));
        repeat (dly) @(negedge clk);
        bus.rom_data  = d;
        bus.rom_valid = 1'b1;
        exp_q.push_back(d);
        @(negedge clk);
        bus.rom_valid = 1'b0;
        chk("fill_rom_req_clear", 32'(bus.rom_req), 32'd0);
        @(negedge clk);
        chk("done_single_pulse", 32'(bus.cache_valid), 32'd0);
        bus.cache_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic hit_read(input logic [19:0] a, input logic [31:0] d, input logic [15:0] exp_hit);
        bus.cache_req  = 1'b1;
        bus.cache_addr = a;
        exp_q.push_back(d);
        @(negedge clk);
        chk("hit_not_early", 32'(bus.cache_valid), 32'd0);
        @(negedge clk);
        chk("hit_valid_latency", 32'(bus.cache_valid), 32'd1);
        chk("hit_rom_req", 32'(bus.rom_req), 32'd0);
        chk("hit_count", 32'(hit_count), 32'(exp_hit));
        @(negedge clk);
        chk("hit_single_pulse", 32'(bus.cache_valid), 32'd0);
        bus.cache_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic start_miss(input logic [19:0] a, input logic [15:0] exp_miss);
        bus.cache_req  = 1'b1;
        bus.cache_addr = a;
        @(negedge clk);
        @(negedge clk);
        chk("miss_rom_req", 32'(bus.rom_req), 32'd1);
        chk("miss_count", 32'(miss_count), 32'(exp_miss));
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cache_req  = 1'b0;
        bus.cache_addr = '0;
        bus.rom_data   = '0;
        bus.rom_valid  = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset_flush_busy", 32'(flush_busy), 32'd1);
        chk("reset_cache_valid", 32'(bus.cache_valid), 32'd0);
        chk("reset_rom_req", 32'(bus.rom_req), 32'd0);
        chk("reset_rom_addr", 32'(bus.rom_addr), 32'd0);
        chk("reset_cache_data", bus.cache_data, 32'd0);
        chk("reset_hit_count", 32'(hit_count), 32'd0);
        chk("reset_miss_count", 32'(miss_count), 32'd0);
        reset = 1'b1;
        measure_flush("reset_flush_len");

        miss_read(20'h00010, 32'hDEADBEEF, 5, 16'd1);
        hit_read(20'h00010, 32'hDEADBEEF, 16'd1);
        miss_read(20'h00210, 32'h12345678, 2, 16'd2);
        miss_read(20'h00010, 32'hDEADBEEF, 1, 16'd3);
        miss_read(20'hFFFFF, 32'hCAFEF00D, 0, 16'd4);
        hit_read(20'hFFFFF, 32'hCAFEF00D, 16'd2);

        // Abort two cycles into FILL, then a late rom_valid must be ignored.
        start_miss(20'h00123, 16'd5);
        repeat (2) @(negedge clk);
        bus.cache_req = 1'b0;
        @(negedge clk);
        chk("abort_rom_req", 32'(bus.rom_req), 32'd0);
        bus.rom_data  = 32'h11111111;
        bus.rom_valid = 1'b1;
        @(negedge clk);
        bus.rom_valid = 1'b0;
        repeat (2) @(negedge clk);

        // rom_valid coinciding with the request dropping is an abort too.
        start_miss(20'h00123, 16'd6);
        @(negedge clk);
        bus.cache_req = 1'b0;
        bus.rom_data  = 32'h22222222;
        bus.rom_valid = 1'b1;
        @(negedge clk);
        bus.rom_valid = 1'b0;
        chk("same_edge_abort_rom_req", 32'(bus.rom_req), 32'd0);
        repeat (2) @(negedge clk);

        miss_read(20'h00123, 32'h0BADC0DE, 3, 16'd7);
        hit_read(20'h00123, 32'h0BADC0DE, 16'd3);

        // Flush during FILL: fill completes first, walk follows.
        start_miss(20'h00400, 16'd8);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        @(negedge clk);
        bus.rom_data  = 32'h40404040;
        bus.rom_valid = 1'b1;
        exp_q.push_back(32'h40404040);
        @(negedge clk);
        bus.rom_valid = 1'b0;
        chk("flush_deferred_rom_req", 32'(bus.rom_req), 32'd0);
        chk("flush_deferred_busy", 32'(flush_busy), 32'd0);
        @(negedge clk);
        bus.cache_req = 1'b0;
        measure_flush("flush_after_fill_len");
        miss_read(20'h00010, 32'hDEADBEEF, 2, 16'd9);

        // A second flush pulse mid-walk restarts at index 0.
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("idle_flush_started", 32'(flush_busy), 32'd1);
        repeat (100) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        measure_flush("flush_restart_len");
        miss_read(20'h00400, 32'h40404040, 1, 16'd10);

        // Reset during FILL drops rom_req immediately.
        start_miss(20'h00777, 16'd11);
        @(negedge clk);
        reset = 1'b0;
        bus.cache_req = 1'b0;
        #1;
        chk("reset_mid_fill_rom_req", 32'(bus.rom_req), 32'd0);
        chk("reset_mid_fill_busy", 32'(flush_busy), 32'd1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        chk("rereset_miss_count", 32'(miss_count), 32'd0);
        measure_flush("rereset_flush_len");

        // Saturation of the miss counter.
        force dut.u_miss_cnt.count = 16'hFFFE;
        @(negedge clk);
        release dut.u_miss_cnt.count;
        @(negedge clk);
        chk("forced_miss_count", 32'(miss_count), 32'h0000FFFE);
        miss_read(20'h00020, 32'h20202020, 0, 16'hFFFF);
        miss_read(20'h00021, 32'h21212121, 0, 16'hFFFF);
        miss_read(20'h00022, 32'h22222222, 0, 16'hFFFF);
        chk("sat_hit_count", 32'(hit_count), 32'd0);

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
